// File: rtl/seq_pattern_detector.sv
// Programmable serial bit-pattern detector. It compares the most recent len accepted bits
// against a loadable pattern and keeps a saturating count of matches.
module seq_pattern_detector #(
  parameter int                   PAT_WIDTH   = 4,
  parameter int                   CNT_WIDTH   = 8,
  parameter logic [PAT_WIDTH-1:0] DEFAULT_PAT = PAT_WIDTH'(4'b1011),
  localparam int                  LEN_W       = $clog2(PAT_WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 sequence_in,
  input  logic                 seq_valid,
  input  logic                 cfg_load,
  input  logic [PAT_WIDTH-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_overlap,
  input  logic                 clear_count,
  output logic                 detector_out,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 cfg_error
);

  localparam int                   DEF_LEN = (PAT_WIDTH < 4) ? PAT_WIDTH : 4;
  localparam logic [LEN_W-1:0]     FULL    = LEN_W'(PAT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [PAT_WIDTH-1:0] pat;
  logic [PAT_WIDTH-1:0] hist;
  logic [PAT_WIDTH-1:0] nh;
  logic [PAT_WIDTH-1:0] mask;
  logic [LEN_W-1:0]     len;
  logic [LEN_W-1:0]     fill;
  logic [LEN_W-1:0]     nf;
  logic                 ovl;
  logic                 match;
  logic                 cfg_ok;
  logic                 hit;

  // Candidate history/fill if the current bit is accepted; mask keeps the low len bits.
  always_comb begin
    nh = {hist[PAT_WIDTH-2:0], sequence_in};
    nf = (fill == FULL) ? FULL : fill + 1'b1;
    for (int i = 0; i < PAT_WIDTH; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    match  = (nf >= len) && (((nh ^ pat) & mask) == '0);
    cfg_ok = (cfg_len != '0) && (cfg_len <= FULL);
    hit    = seq_valid && !cfg_load && match;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pat          <= DEFAULT_PAT;
      len          <= LEN_W'(DEF_LEN);
      ovl          <= 1'b1;
      hist         <= '0;
      fill         <= '0;
      detector_out <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      detector_out <= 1'b0;
      if (cfg_load) begin
        // A rejected load leaves the running configuration and history untouched.
        if (cfg_ok) begin
          pat       <= cfg_pattern;
          len       <= cfg_len;
          ovl       <= cfg_overlap;
          hist      <= '0;
          fill      <= '0;
          cfg_error <= 1'b0;
        end else begin
          cfg_error <= 1'b1;
        end
      end else if (seq_valid) begin
        hist         <= nh;
        detector_out <= match;
        fill         <= (match && !ovl) ? '0 : nf;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      match_count <= '0;
    end else if (clear_count) begin
      match_count <= '0;
    end else if (hit && (match_count != CNT_MAX)) begin
      match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Programmable serial bit-pattern detector; the parametrised successor to the fixed-pattern Moore detector. It samples one qualified bit per cycle and compares the most recent `len` bits against a run-time loadable pattern of up to PAT_WIDTH bits. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits on the serial input path and feeds the status and interrupt logic.

## Interface
- PAT_WIDTH, 4: maximum pattern length in bits; legal range 2..16.
- CNT_WIDTH, 8: width of the match counter.
- DEFAULT_PAT, 4'b1011 (zero-extended to PAT_WIDTH): pattern loaded at reset. Default length is 4 and overlap mode is on.
- LEN_W (localparam) = $clog2(PAT_WIDTH+1).

- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sequence_in  in  1  serial data bit.
- seq_valid  in  1  qualifies sequence_in in this cycle.
- cfg_load  in  1  one-cycle strobe that captures cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  PAT_WIDTH  new pattern. Bit [len-1] is the first bit received; bit [0] is the last.
- cfg_len  in  LEN_W  new pattern length; legal range 1..PAT_WIDTH.
- cfg_overlap  in  1  1 = overlapping detection; 0 = non-overlapping.
- clear_count  in  1  synchronous clear of match_count.
- detector_out  out  1  one-cycle match pulse, registered.
- match_count  out  CNT_WIDTH  saturating count of matches.
- cfg_error  out  1  sticky flag: the last cfg_load was rejected.

## Operation
**Internal state**
- pat, len, ovl: active configuration registers.
- hist[PAT_WIDTH-1:0]: bit history; the newest bit is at hist[0].
- fill: number of valid history bits, 0..PAT_WIDTH.

**Reset (reset_n low)**
- pat = DEFAULT_PAT, len = 4, ovl = 1.
- hist = 0, fill = 0.
- detector_out = 0, match_count = 0, cfg_error = 0.

**Bit acceptance** (seq_valid = 1 and cfg_load = 0)
- nh = {hist[PAT_WIDTH-2:0], sequence_in}.
- nf = min(fill+1, PAT_WIDTH).
- match = (nf >= len) and (nh[len-1:0] == pat[len-1:0]).
- Update: hist <= nh, detector_out <= match.
- fill <= (match and not ovl) ? 0 : nf. Non-overlap mode discards every bit of a matched sequence.

**seq_valid = 0**
- hist and fill hold.
- detector_out <= 0.

**cfg_load = 1** (has priority over seq_valid; the bit in that cycle is dropped)
- Legal cfg_len (1..PAT_WIDTH):
  - pat, len and ovl are captured.
  - hist <= 0, fill <= 0, detector_out <= 0, cfg_error <= 0.
- Illegal cfg_len (0 or > PAT_WIDTH):
  - Configuration, hist and fill are unchanged.
  - cfg_error <= 1, detector_out <= 0.
- match_count is not affected by cfg_load.

**match_count**
- Increments by 1 on every cycle in which detector_out is loaded with 1.
- Saturates at 2^CNT_WIDTH-1.
- clear_count has priority: when clear_count and a match occur in the same cycle, the count becomes 0.

## Timing
- Latency: detector_out rises on the clock edge that samples the completing bit. It is visible for exactly one cycle after that edge unless the next accepted bit also matches.
- Back-to-back pulses occur only in overlap mode, or with len = 1 in either mode.
- The first match is possible no earlier than the len-th accepted bit after reset or a legal cfg_load.
- Reset mid-stream: all partial history is lost immediately (asynchronous). The first edge after reset_n deasserts samples normally.
- Gaps in seq_valid never break a partial match. Only accepted bits count.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Defaults, overlap: reset, then accept 1,0,1,1,0,1,1 -> detector_out pulses after the 4th and the 7th bit. match_count = 2.
- Non-overlap: load pat = 2'b11, len = 2, overlap = 0, then accept 1,1,1,1,1 -> pulses after bits 2 and 4 only. match_count = 2. With overlap = 1 the same input gives pulses after bits 2, 3, 4 and 5.
- Gapped input: defaults, then bits 1,0 followed by 3 cycles of seq_valid = 0, then 1,1 -> a single pulse after the final 1. detector_out stays 0 during the gap.
- Bad config: cfg_len = 0 -> cfg_error = 1 and the 1011 pattern still detects. A following legal load clears cfg_error and flushes history, so a 1,0,1 prefix sent before the load does not complete a match.
- Saturation and clear: CNT_WIDTH = 2, stream 6 matches -> match_count stops at 3. clear_count asserted on a match cycle -> match_count = 0.
- Reset mid-operation: assert reset_n low after 1,0,1, release, then send 1 -> no pulse. Continue with 0,1,1 -> pulse.
